retire_trace_fifo: RTL and testbench
====================================

Name: retire_trace_fifo

Overview:
- Downstream consumer of the single_cycle core's retirement outputs: pc, instruction, rd, rf_write_en, mem_write_en.
- Captures one trace record per retired instruction into a small FIFO and tags it with a sequence number.
- Presents records on a valid/ready read port for a trace drain (UART/debug bridge or testbench scoreboard).
- Keeps retire, drop and overflow statistics, so a slow drain never stalls the core and lost records stay detectable.

Parameters:
- XLEN, 32, datapath width of pc and rd.
- DEPTH, 8, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of FIFO contents and overflow flag.
- in_valid  input  1  an instruction retired this cycle; tie to 1 for single_cycle.
- pc  input  XLEN  pc of the retiring instruction.
- instruction  input  32  instruction word.
- rd  input  XLEN  value written or computed for rd.
- rf_write_en  input  1  register-file write enable.
- mem_write_en  input  1  data-memory write enable.
- out_valid  output  1  head record available.
- out_ready  input  1  drain accepts head record.
- out_seq  output  32  sequence number of head record.
- out_pc  output  XLEN  head pc.
- out_instruction  output  32  head instruction.
- out_rd  output  XLEN  head rd.
- out_rf_write_en  output  1  head rf_write_en.
- out_mem_write_en  output  1  head mem_write_en.
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky; at least one record dropped.
- dropped_count  output  16  saturating drop counter.
- retired_count  output  32  total in_valid cycles since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - Read and write pointers, count, overflow, dropped_count, retired_count and the sequence counter all go to 0.
  - out_valid goes to 0 immediately, without waiting for a clock.
  - Storage contents need not be cleared.
- Record format: {seq, pc, instruction, rd, rf_write_en, mem_write_en}.
- Sequence counter:
  - Increments (mod 2^32) on every cycle with in_valid=1, whether or not the record is stored.
  - A gap in out_seq therefore marks dropped records.
  - retired_count always equals the sequence counter.
- Pointers: $clog2(DEPTH) bits plus one wrap bit; full and empty are derived from the pointers; count = wptr - rptr.
- Push: in_valid=1 and (not full, or a pop happens in the same cycle). The record is written at wptr on the rising edge.
- Drop: in_valid=1, full, and no pop this cycle.
  - Record discarded.
  - overflow set to 1.
  - dropped_count incremented, saturating at 0xFFFF.
- Pop: out_valid=1 and out_ready=1; rptr advances on the edge.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - When full, a pop frees the slot in the same cycle, so there is no drop.
- Read port is first-word-fall-through:
  - out_valid = !empty.
  - out_* are driven combinationally from the storage entry at rptr.
- Latency:
  - A record pushed at edge N is visible on out_* after edge N; it can be popped at edge N+1 at the earliest.
  - No combinational input-to-output bypass exists; an empty FIFO stays out_valid=0 during the push cycle.
- out_* are only meaningful when out_valid=1 (bench must not check them otherwise).
- Holding rule: while out_valid=1 and out_ready=0, out_* stay stable across cycles, including cycles with pushes.
- clear=1 on an edge:
  - Pointers reset, count=0, overflow=0, dropped_count=0.
  - retired_count and the sequence counter are retained.
  - A push in the same cycle is discarded but still counted in seq/retired_count.
  - clear takes priority over push and pop.
- Wrap-around: pointers wrap modulo 2*DEPTH; ordering is preserved across wraps.
- Mid-operation reset discards all buffered records.

Test Plan:
- Hold reset=0, then release → out_valid=0, count=0, overflow=0, dropped_count=0, retired_count=0.
- out_ready=0; push pc=0x0, 0x4, 0x8 (instructions 0x00500093, 0x00A00113, 0x002081B3) → count=3, out_valid=1 one edge after the first push; out_pc=0x0, out_seq=0. Then out_ready=1 → three pops in order with seq 0, 1, 2, and count=0 after them.
- DEPTH=8, out_ready=0, 10 consecutive pushes → count=8, overflow=1, dropped_count=2, retired_count=10. Draining yields seq 0..7 only.
- FIFO full, in_valid=1 and out_ready=1 for 5 cycles → count stays 8, dropped_count unchanged; output seq continues contiguously.
- out_ready=1 continuously with 20 pushes (forces pointer wrap at DEPTH=8) → every record pops one cycle after its push, out_seq 0..19 monotonic, count never exceeds 1, overflow=0.
- Mid-stream clear=1 with count=5 → next cycle count=0, out_valid=0, overflow=0, retired_count unchanged. Then assert reset between clock edges → out_valid=0 and retired_count=0 before the next clk edge.

Source files
------------

// File: rtl/retire_trace_fifo.sv
// Retirement trace FIFO: tags each retired instruction with a sequence number and
// buffers it for a first-word-fall-through valid/ready drain, counting drops.
module retire_trace_fifo #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [XLEN-1:0]         pc,
    input  logic [31:0]             instruction,
    input  logic [XLEN-1:0]         rd,
    input  logic                    rf_write_en,
    input  logic                    mem_write_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_seq,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_instruction,
    output logic [XLEN-1:0]         out_rd,
    output logic                    out_rf_write_en,
    output logic                    out_mem_write_en,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [15:0]             dropped_count,
    output logic [31:0]             retired_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [31:0]     seq;
        logic [XLEN-1:0] pc;
        logic [31:0]     instruction;
        logic [XLEN-1:0] rd;
        logic            rf_write_en;
        logic            mem_write_en;
    } rec_t;

    rec_t        mem_q [DEPTH];
    rec_t        wr_rec;
    rec_t        head;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        overflow_q, overflow_d;
    logic [15:0] dropped_q, dropped_d;
    logic [31:0] seq_q, seq_d;
    logic        empty, full, push, pop, drop, wr_en;

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop   = !empty && out_ready;
        // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
        push  = in_valid && (!full || pop);
        drop  = in_valid && full && !pop;
        wr_en = push && !clear;

        wr_rec = '{seq: seq_q, pc: pc, instruction: instruction, rd: rd,
                   rf_write_en: rf_write_en, mem_write_en: mem_write_en};

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        seq_d      = in_valid ? seq_q + 32'd1 : seq_q;

        if (clear) begin
            wptr_d     = '0;
            rptr_d     = '0;
            overflow_d = 1'b0;
            dropped_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_ONE;
            if (pop)  rptr_d = rptr_q + PTR_ONE;
            if (drop) begin
                overflow_d = 1'b1;
                if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            seq_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            seq_q      <= seq_d;
        end
    end

    // Storage is not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_rec;
    end

    always_comb begin
        head             = mem_q[rptr_q[AW-1:0]];
        out_valid        = !empty;
        out_seq          = head.seq;
        out_pc           = head.pc;
        out_instruction  = head.instruction;
        out_rd           = head.rd;
        out_rf_write_en  = head.rf_write_en;
        out_mem_write_en = head.mem_write_en;
        count            = wptr_q - rptr_q;
        overflow         = overflow_q;
        dropped_count    = dropped_q;
        retired_count    = seq_q;
    end
endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo against a queue-based model of the
// retirement trace buffer.
module tb_retire_trace_fifo;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic [31:0]     instruction = '0;
    logic [XLEN-1:0] rd = '0;
    logic            rf_write_en = 1'b0;
    logic            mem_write_en = 1'b0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [31:0]     out_seq;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instruction;
    logic [XLEN-1:0] out_rd;
    logic            out_rf_write_en;
    logic            out_mem_write_en;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [15:0]     dropped_count;
    logic [31:0]     retired_count;

    always #5 clk = ~clk;

    retire_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .pc(pc),
        .instruction(instruction), .rd(rd), .rf_write_en(rf_write_en),
        .mem_write_en(mem_write_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_seq(out_seq), .out_pc(out_pc), .out_instruction(out_instruction),
        .out_rd(out_rd), .out_rf_write_en(out_rf_write_en),
        .out_mem_write_en(out_mem_write_en), .count(count), .overflow(overflow),
        .dropped_count(dropped_count), .retired_count(retired_count)
    );

    typedef struct {
        logic [31:0]     seq;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] rd;
        logic            rf;
        logic            mw;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_seq = '0;
    logic        m_ovf = 1'b0;
    int unsigned m_drop = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model: a queue of records updated on each active edge.
    always @(posedge clk) begin : model
        bit   do_pop;
        rec_t r;
        if (reset) begin
            do_pop = (mq.size() > 0) && out_ready;
            if (clear) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_drop = 0;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (in_valid) begin
                    if (mq.size() < DEPTH) begin
                        r.seq = m_seq; r.pc = pc; r.instr = instruction; r.rd = rd;
                        r.rf = rf_write_en; r.mw = mem_write_en;
                        mq.push_back(r);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop < 65535) m_drop++;
                    end
                end
            end
            if (in_valid) m_seq = m_seq + 32'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_seq  = '0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic set_rand();
        pc           = XLEN'($urandom) & ~XLEN'(3);
        instruction  = $urandom;
        rd           = XLEN'($urandom);
        rf_write_en  = 1'($urandom);
        mem_write_en = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b want 0", out_valid); end
        reset = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        checks++; if (dropped_count !== 16'd0) begin errors++; $display("FAIL rst_dropped: got %0d want 0", dropped_count); end
        checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL rst_retired: got %0d want 0", retired_count); end
    endtask

    task automatic test_basic();
        logic [31:0] instrs [3];
        instrs[0] = 32'h00500093; instrs[1] = 32'h00A00113; instrs[2] = 32'h002081B3;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; pc = XLEN'(4 * i); instruction = instrs[i];
            rd = XLEN'(5 * (i + 1)); rf_write_en = 1'b1; mem_write_en = 1'b0;
            if (i == 0) begin
                #1;
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: got %b want 0", out_valid); end
            end
            tick();
            if (i == 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got %b want 1", out_valid); end
                checks++; if (out_pc !== XLEN'(0)) begin errors++; $display("FAIL basic_first_pc: got %h want 0", out_pc); end
                checks++; if (out_seq !== 32'd0) begin errors++; $display("FAIL basic_first_seq: got %0d want 0", out_seq); end
            end
        end
        in_valid = 1'b0;
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL basic_count3: got %0d want 3", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_seq !== 32'(i) || out_pc !== XLEN'(4 * i) || out_instruction !== instrs[i])
                begin errors++; $display("FAIL basic_pop%0d: got v=%b seq=%0d pc=%h ins=%h want v=1 seq=%0d pc=%h ins=%h",
                                         i, out_valid, out_seq, out_pc, out_instruction, i, 4 * i, instrs[i]); end
            tick();
        end
        checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got count=%0d v=%b want 0 0", count, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_rand(); in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d want %0d", count, DEPTH); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (dropped_count !== 16'd2) begin errors++; $display("FAIL ovf_dropped: got %0d want 2", dropped_count); end
        checks++; if (retired_count !== 32'd10) begin errors++; $display("FAIL ovf_retired: got %0d want 10", retired_count); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_seq !== 32'(i) || out_pc !== mq[0].pc || out_rd !== mq[0].rd)
                begin errors++; $display("FAIL ovf_drain%0d: got v=%b seq=%0d pc=%h rd=%h want v=1 seq=%0d pc=%h rd=%h",
                                         i, out_valid, out_seq, out_pc, out_rd, i, mq[0].pc, mq[0].rd); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_extra: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_rand(); in_valid = 1'b1; tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_rand(); in_valid = 1'b1;
            checks++; if (count !== CW'(DEPTH) || dropped_count !== 16'd0 || out_seq !== 32'(i))
                begin errors++; $display("FAIL full_pp%0d: got count=%0d drop=%0d seq=%0d want %0d 0 %0d",
                                         i, count, dropped_count, out_seq, DEPTH, i); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== CW'(DEPTH) || dropped_count !== 16'd0 || overflow !== 1'b0)
            begin errors++; $display("FAIL full_pp_end: got count=%0d drop=%0d ovf=%b want %0d 0 0", count, dropped_count, overflow, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_seq !== 32'(5 + i) || out_instruction !== mq[0].instr ||
                          out_rf_write_en !== mq[0].rf || out_mem_write_en !== mq[0].mw)
                begin errors++; $display("FAIL full_drain%0d: got v=%b seq=%0d ins=%h want v=1 seq=%0d ins=%h",
                                         i, out_valid, out_seq, out_instruction, 5 + i, mq[0].instr); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rand(); in_valid = 1'b1;
            tick();
            checks++; if (out_valid !== 1'b1 || out_seq !== 32'(i) || out_pc !== mq[0].pc || count > CW'(1) || overflow !== 1'b0)
                begin errors++; $display("FAIL b2b%0d: got v=%b seq=%0d pc=%h count=%0d ovf=%b want v=1 seq=%0d pc=%h count<=1 ovf=0",
                                         i, out_valid, out_seq, out_pc, count, overflow, i, mq[0].pc); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL b2b_end: got v=%b count=%0d want 0 0", out_valid, count); end
        out_ready = 1'b0;
    endtask

    task automatic test_clear_and_reset();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_rand(); in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== CW'(5)) begin errors++; $display("FAIL clr_pre_count: got %0d want 5", count); end
        clear = 1'b1; in_valid = 1'b1; set_rand();
        tick();
        clear = 1'b0; in_valid = 1'b0;
        checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_empty: got count=%0d v=%b want 0 0", count, out_valid); end
        checks++; if (overflow !== 1'b0 || dropped_count !== 16'd0) begin errors++; $display("FAIL clr_stats: got ovf=%b drop=%0d want 0 0", overflow, dropped_count); end
        checks++; if (retired_count !== 32'd6) begin errors++; $display("FAIL clr_retired: got %0d want 6", retired_count); end
        set_rand(); in_valid = 1'b1; tick(); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_seq !== 32'd6) begin errors++; $display("FAIL clr_next_seq: got v=%b seq=%0d want 1 6", out_valid, out_seq); end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", out_valid); end
        checks++; if (retired_count !== 32'd0 || count !== '0) begin errors++; $display("FAIL async_counts: got ret=%0d count=%0d want 0 0", retired_count, count); end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 79) == 0);
            checks++; if (out_valid !== (mq.size() > 0) || int'(count) != mq.size())
                begin errors++; $display("FAIL rnd_occ@%0d: got v=%b count=%0d want v=%b count=%0d", c, out_valid, count, mq.size() > 0, mq.size()); end
            checks++; if (overflow !== m_ovf || dropped_count !== 16'(m_drop) || retired_count !== m_seq)
                begin errors++; $display("FAIL rnd_stats@%0d: got ovf=%b drop=%0d ret=%0d want %b %0d %0d", c, overflow, dropped_count, retired_count, m_ovf, m_drop, m_seq); end
            if (mq.size() > 0) begin
                checks++; if (out_seq !== mq[0].seq || out_pc !== mq[0].pc || out_instruction !== mq[0].instr ||
                              out_rd !== mq[0].rd || out_rf_write_en !== mq[0].rf || out_mem_write_en !== mq[0].mw)
                    begin errors++; $display("FAIL rnd_head@%0d: got seq=%0d pc=%h ins=%h want seq=%0d pc=%h ins=%h",
                                             c, out_seq, out_pc, out_instruction, mq[0].seq, mq[0].pc, mq[0].instr); end
            end
            tick();
        end
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_clear_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
